// File: rtl/div_iter_radix2_pkg.sv
// Shared constants for the iterative divider and the ALU stall logic that
// waits on it.
package div_iter_radix2_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_step_cell.sv
// One restoring radix-2 iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference or restore.
module div_step_cell #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, dvd_msb_i};
  assign diff    = shifted - {1'b0, divisor_i};

  // Partial remainder is always below the divisor, so the restored value fits
  // in WIDTH bits and diff's top bit is a reliable sign.
  assign q_bit_o = ~diff[WIDTH];
  assign rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_iter_radix2.sv
// Multi-cycle restoring radix-2 divider producing {remainder, quotient} for
// signed or unsigned operands; one quotient bit per cycle.
//
// state      | meaning
// DIV_FREE   | idle, waiting for start_i
// DIV_BYZERO | divisor was zero, zero result issued next edge
// DIV_ON     | iterating, one quotient bit per cycle
// DIV_END    | result valid, held until start_i drops
module div_iter_radix2
  import div_iter_radix2_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   rem_q;
  logic               sgn_q;
  logic               s1_q;
  logic               s2_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  logic [WIDTH-1:0]   rem_d;
  logic               q_bit_d;
  logic [WIDTH-1:0]   quo_d;
  logic [WIDTH-1:0]   quo_fix_d;
  logic [WIDTH-1:0]   rem_fix_d;
  logic [WIDTH-1:0]   abs1_d;
  logic [WIDTH-1:0]   abs2_d;

  div_step_cell #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (rem_d),
    .q_bit_o   (q_bit_d)
  );

  // Quotient bits accumulate in the low end of the dividend register as the
  // dividend bits are shifted out of the top.
  assign quo_d     = {dvd_q[WIDTH-2:0], q_bit_d};
  assign quo_fix_d = (sgn_q && (s1_q ^ s2_q)) ? (~quo_d + ONE) : quo_d;
  assign rem_fix_d = (sgn_q && s1_q) ? (~rem_d + ONE) : rem_d;

  assign abs1_d = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + ONE) : opdata1_i;
  assign abs2_d = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + ONE) : opdata2_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      sgn_q    <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      result_q <= '0;
      ready_q  <= DIV_RESULT_NOT_READY;
    end else begin
      unique case (state_q)
        DIV_FREE: begin
          result_q <= '0;
          ready_q  <= DIV_RESULT_NOT_READY;
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == '0) begin
              state_q <= DIV_BYZERO;
            end else begin
              state_q <= DIV_ON;
              dvd_q   <= abs1_d;
              dvs_q   <= abs2_d;
              rem_q   <= '0;
              cnt_q   <= '0;
              sgn_q   <= signed_div_i;
              s1_q    <= opdata1_i[WIDTH-1];
              s2_q    <= opdata2_i[WIDTH-1];
            end
          end
        end
        DIV_BYZERO: begin
          state_q  <= DIV_END;
          result_q <= '0;
          ready_q  <= DIV_RESULT_READY;
        end
        DIV_ON: begin
          if (annul_i) begin
            state_q <= DIV_FREE;
          end else begin
            dvd_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              state_q  <= DIV_END;
              result_q <= {rem_fix_d, quo_fix_d};
              ready_q  <= DIV_RESULT_READY;
            end
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            state_q  <= DIV_FREE;
            result_q <= '0;
            ready_q  <= DIV_RESULT_NOT_READY;
          end
        end
        default: state_q <= DIV_FREE;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter_radix2.sv
// Directed bench for div_iter_radix2: hand-computed quotient/remainder pairs,
// latency edges, divide-by-zero, annul and mid-divide reset.
module tb_div_iter_radix2;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  div_iter_radix2 dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full divide with start held: ready low through edge 32, result after 33,
  // held one more cycle, then cleared one cycle after start drops.
  task automatic div_run(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input bit mutate);
    logic early;
    early = 1'b0;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      tick();
      early |= ready_o;
      if (mutate && e == 1) begin
        opdata1_i    = 32'h0000_0005;
        opdata2_i    = 32'h0000_0003;
        signed_div_i = ~sgn;
      end
    end
    chk({tag, "_early_ready"}, 64'(early), 64'd0);
    tick();
    chk({tag, "_ready"}, 64'(ready_o), 64'd1);
    chk({tag, "_result"}, result_o, exp);
    tick();
    chk({tag, "_hold"}, {result_o[62:0], ready_o}, {exp[62:0], 1'b1});
    @(negedge clk);
    start_i = 1'b0;
    tick();
    chk({tag, "_clear"}, {result_o[62:0], ready_o}, 64'd0);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    tick(); tick();
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    div_run("u100_7",   1'b0, 32'd100,       32'd7,        {32'd2, 32'd14}, 1'b0);
    div_run("s_m7_2",   1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    div_run("s_7_m2",   1'b1, 32'h0000_0007, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0);
    div_run("s_m100_m7",1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, 1'b0);
    div_run("u_hex",    1'b0, 32'h1234_5678, 32'h0000_0100, {32'h0000_0078, 32'h0012_3456}, 1'b0);
    div_run("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 1'b1);

    // Divide by zero.
    @(negedge clk);
    signed_div_i = 1'b1; opdata1_i = 32'h1234_5678; opdata2_i = 32'h0; start_i = 1'b1;
    tick();
    chk("byzero_edge1", 64'(ready_o), 64'd0);
    tick();
    chk("byzero_edge2", {result_o[62:0], ready_o}, 64'd1);
    tick(); tick(); tick();
    chk("byzero_hold", {result_o[62:0], ready_o}, 64'd1);
    @(negedge clk);
    start_i = 1'b0;
    tick();
    chk("byzero_clear", 64'(ready_o), 64'd0);

    // Annul at edge 10, then a fresh divide.
    seen = 1'b0;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      seen |= ready_o;
    end
    @(negedge clk);
    annul_i = 1'b1;
    tick();
    seen |= ready_o;
    chk("annul_result", result_o, 64'd0);
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    for (int e = 0; e < 30; e++) begin
      tick();
      seen |= ready_o;
    end
    chk("annul_no_ready", 64'(seen), 64'd0);
    div_run("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 1'b0);

    // Reset at edge 20 of a divide, then a normal divide.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1;
    for (int e = 1; e <= 19; e++) tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rst_mid", {result_o[62:0], ready_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    seen = 1'b0;
    for (int e = 0; e < 34; e++) begin
      tick();
      seen |= ready_o;
    end
    chk("rst_no_ready", 64'(seen), 64'd0);
    div_run("u50_5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_iter_radix2.md
Name: div_iter_radix2

Overview:
- Multi-cycle, restoring radix-2 integer divider that feeds the EX-stage ALU.
- The ALU raises start_i for DIV/DIVU, stalls the pipeline while ready_o is low, and writes result_o into HI/LO when ready_o goes high.
- Produces {remainder, quotient} for signed or unsigned 32-bit operands.
- Supports abort (annul_i) when an exception or flush kills the divide in EX.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH; iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must be at least clog2(WIDTH)+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start.
- opdata1_i  in  WIDTH  dividend; sampled at start.
- opdata2_i  in  WIDTH  divisor; sampled at start.
- start_i  in  1  request; held high by the ALU until it sees ready_o.
- annul_i  in  1  abort the in-flight divide.
- result_o  out  2*WIDTH  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
- ready_o  out  1  result valid.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- All outputs are registered. On rst: state = FREE, result_o = 0, ready_o = 0, counter = 0, internal operands = 0.
- rst has priority over every other event, including a divide in progress.

State machine (FREE, BYZERO, ON, END):
- FREE:
  - start_i=1, annul_i=0, divisor==0 -> BYZERO.
  - start_i=1, annul_i=0, divisor!=0 -> ON. Capture |dividend| and |divisor| (two's-complement negate when signed_div_i=1 and MSB=1). Latch signed_div_i and both operand sign bits. Clear counter. Partial remainder = 0.
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- BYZERO:
  - Next edge -> END with result_o = 0 and ready_o = 1.
  - No trap is raised; the MIPS result is architecturally undefined.
- ON: one iteration per cycle.
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor from the upper WIDTH+1 bits.
  - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - Increment the counter.
  - On the edge that performs iteration WIDTH (counter = WIDTH-1) -> END, load result_o, and set ready_o=1.
  - Sign fix-up in the same edge: if signed, quotient is negated when the operand signs differ, and remainder takes the dividend's sign.
  - annul_i=1 in ON -> FREE next edge; ready_o stays 0 and result_o stays 0. Partial state is discarded.
- END:
  - ready_o=1 and result_o held stable while start_i=1.
  - start_i=0 -> FREE next edge, clearing ready_o and result_o to 0.
  - annul_i is ignored in END.

Latency (edge 1 = the edge that samples start_i):
- Normal divide: ready_o rises after edge WIDTH+1 (edge 33).
- Divide by zero: ready_o rises after edge 2.
- Back-to-back divides: a new start_i is accepted in FREE one cycle after END exits.

Other rules:
- Operand changes during ON are ignored; only the values captured at start are used.
- Signed -2^31 / -1 wraps: quotient 0x80000000, remainder 0, no overflow flag.
- Only arithmetic modulo 2^WIDTH is used; negation is ~x+1.

Decomposition:
- Shared package holds:
  - State encoding constants: DIV_FREE=2'b00, DIV_BYZERO=2'b01, DIV_ON=2'b10, DIV_END=2'b11.
  - DIV_RESULT_READY / DIV_RESULT_NOT_READY.
  - DIV_START / DIV_STOP.
  - These are reused by the ALU's stall logic.
- One natural sub-module: div_step_cell, a combinational trial subtract plus select for one iteration, instantiated once inside the sequential loop.

Test Plan:
- Unsigned 100/7, start held high -> ready_o=0 through edge 32; after edge 33 result_o = {32'd2, 32'd14}. Drop start -> ready_o=0 and result_o=0 next cycle.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Also 7/-2 -> {0x00000001, 0xFFFFFFFD}.
- Divisor 0 (dividend 0x12345678, signed) -> after edge 2 ready_o=1, result_o=0. Stays held while start_i=1.
- annul_i pulsed at edge 10 of an ON divide -> FREE, ready_o never rises. A fresh start of 0xFFFFFFFF/1 unsigned on the next cycle -> {0, 0xFFFFFFFF} after 33 edges.
- rst asserted at edge 20 mid-divide -> next cycle ready_o=0, result_o=0, state FREE. Divide after release completes normally.
- Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}, no hang. Opdata changes during ON do not alter the result.
